moving_avg_ctrl: RTL and testbench

//  Upstream controller for the 8x12 sample RAM. Accepts 12-bit samples and runs the RAM as a circular buffer.

---
 rtl/movavg_pkg.sv | 26 ++
 rtl/moving_avg_ctrl_if.sv | 35 +++
 rtl/moving_avg_ctrl.sv | 129 ++++++++++++
 tb/tb_moving_avg_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/movavg_pkg.sv
// ---------------------------------------------------------------------------
// movavg_pkg
// Shared constants and types for the moving-average controller.
//   WIDTH      : sample width, equal to the RAM data width
//   DEPTH_LOG2 : log2 of the averaging window, equal to the RAM address width
//   DEPTH      : window length in samples
//   SUM_W      : running-sum width; wide enough that it never overflows
//   FILL_W     : width of the fill counter, which counts 0..DEPTH
//   state_t    : controller FSM states
// ---------------------------------------------------------------------------
package movavg_pkg;

  localparam int WIDTH      = 12;
  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH      = 2 ** DEPTH_LOG2;
  localparam int SUM_W      = WIDTH + DEPTH_LOG2;
  localparam int FILL_W     = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    UPDATE = 2'd2,
    OUT    = 2'd3
  } state_t;

endpackage

// File: rtl/moving_avg_ctrl_if.sv
// ---------------------------------------------------------------------------
// moving_avg_ctrl_if
// Groups the signals of the moving-average controller into three bundles.
//   Sample stream : in_valid, in_sample, in_ready
//   Result        : out_valid, out_avg
//   RAM port      : mem_we, mem_a, mem_wd, mem_rd (mem_rd is a combinational
//                   read of mem_a)
// Modports:
//   slave  : the controller itself
//   master : the surrounding logic (sample source, RAM, result consumer)
// ---------------------------------------------------------------------------
interface moving_avg_ctrl_if;
  import movavg_pkg::*;

  logic                  in_valid;
  logic [WIDTH-1:0]      in_sample;
  logic                  in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_avg;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_a;
  logic [WIDTH-1:0]      mem_wd;
  logic [WIDTH-1:0]      mem_rd;

  modport slave (
    input  in_valid, in_sample, mem_rd,
    output in_ready, out_valid, out_avg, mem_we, mem_a, mem_wd
  );

  modport master (
    output in_valid, in_sample, mem_rd,
    input  in_ready, out_valid, out_avg, mem_we, mem_a, mem_wd
  );

endinterface

// File: rtl/moving_avg_ctrl.sv
// ---------------------------------------------------------------------------
// moving_avg_ctrl
// Runs an external 8x12 RAM as a circular buffer of the most recent samples.
// It keeps a running sum of that window and publishes the moving average
// (sum >> DEPTH_LOG2, floor). Each sample takes four cycles:
// IDLE (accept) -> READ (fetch the oldest sample) -> UPDATE (RAM write and
// sum update) -> OUT (out_valid pulse).
// Ports:
//   clk     : system clock
//   reset_n : synchronous active-low reset
//   clear   : synchronous flush; empties the window and keeps the RAM contents
//   bypass  : only present when MOVAVG_BYPASS_EN is defined; out_avg then
//             takes the raw sample, while the window is still maintained
//   bus     : moving_avg_ctrl_if.slave (sample stream, result, RAM port)
// Optional feature macro: MOVAVG_BYPASS_EN
// ---------------------------------------------------------------------------
module moving_avg_ctrl
  import movavg_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
`ifdef MOVAVG_BYPASS_EN
  input  logic bypass,
`endif
  moving_avg_ctrl_if.slave bus
);

  state_t                r_state;
  logic [WIDTH-1:0]      r_sample;
  logic [WIDTH-1:0]      r_old;
  logic [SUM_W-1:0]      r_sum;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FILL_W-1:0]     r_fill;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [WIDTH-1:0]      r_out_avg;
  logic                  r_mem_we;
  logic [WIDTH-1:0]      r_mem_wd;

  logic [SUM_W-1:0]      w_sum_next;
  logic [WIDTH-1:0]      w_avg;
  logic [WIDTH-1:0]      w_out_load;

  // The oldest sample leaves the window and the new sample enters it.
  // r_old is zero until the window is full.
  assign w_sum_next = r_sum - {{DEPTH_LOG2{1'b0}}, r_old} + {{DEPTH_LOG2{1'b0}}, r_sample};
  assign w_avg      = w_sum_next[SUM_W-1:DEPTH_LOG2];

`ifdef MOVAVG_BYPASS_EN
  assign w_out_load = bypass ? r_sample : w_avg;
`else
  assign w_out_load = w_avg;
`endif

  // Controller FSM: sample handshake, window bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_sample    <= {WIDTH{1'b0}};
      r_old       <= {WIDTH{1'b0}};
      r_sum       <= {SUM_W{1'b0}};
      r_wr_ptr    <= {DEPTH_LOG2{1'b0}};
      r_fill      <= {FILL_W{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_avg   <= {WIDTH{1'b0}};
      r_mem_we    <= 1'b0;
      r_mem_wd    <= {WIDTH{1'b0}};
    end else if (clear) begin
      // The flush drops any sample in flight. out_avg keeps its last value.
      r_state     <= IDLE;
      r_sum       <= {SUM_W{1'b0}};
      r_wr_ptr    <= {DEPTH_LOG2{1'b0}};
      r_fill      <= {FILL_W{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_mem_we    <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_sample   <= bus.in_sample;
            r_in_ready <= 1'b0;
            r_state    <= READ;
          end else begin
            r_state    <= IDLE;
          end
        end
        READ: begin
          // The RAM is never cleared, so its slot is only trusted once the
          // window has been filled since the last reset or clear.
          r_old    <= (r_fill == FILL_W'(DEPTH)) ? bus.mem_rd : {WIDTH{1'b0}};
          r_mem_we <= 1'b1;
          r_mem_wd <= r_sample;
          r_state  <= UPDATE;
        end
        UPDATE: begin
          r_sum       <= w_sum_next;
          r_wr_ptr    <= r_wr_ptr + DEPTH_LOG2'(1);
          r_fill      <= (r_fill == FILL_W'(DEPTH)) ? r_fill : r_fill + FILL_W'(1);
          r_out_valid <= 1'b1;
          r_out_avg   <= w_out_load;
          r_state     <= OUT;
        end
        OUT: begin
          r_in_ready <= 1'b1;
          r_state    <= IDLE;
        end
        default: begin
          r_in_ready <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_avg   = r_out_avg;
  assign bus.mem_a     = r_wr_ptr;
  assign bus.mem_wd    = r_mem_wd;
  // The write strobe is registered. It is also qualified by reset_n and clear
  // so that a reset or flush arriving during UPDATE cancels the RAM write.
  assign bus.mem_we    = r_mem_we & reset_n & ~clear;

endmodule

// File: tb/tb_moving_avg_ctrl.sv
module tb_moving_avg_ctrl;
  import movavg_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic preload = 1'b0;
`ifdef MOVAVG_BYPASS_EN
  logic bypass = 1'b0;
`endif

  moving_avg_ctrl_if bus ();

  moving_avg_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
`ifdef MOVAVG_BYPASS_EN
    .bypass  (bypass),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // 8x12 RAM model: combinational read, write on the rising edge
  logic [WIDTH-1:0] ram [DEPTH];
  assign bus.mem_rd = ram[bus.mem_a];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 12'd1000;
    end else if (bus.mem_we) begin
      ram[bus.mem_a] <= bus.mem_wd;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // scoreboard queues and window model
  logic [WIDTH-1:0]              exp_avg_q [$];
  logic [DEPTH_LOG2+WIDTH-1:0]   exp_wr_q  [$];
  int                            hist      [$];
  int                            mptr = 0;
  int acc_cyc = 0, we_cyc = 0, ov_cyc = 0, we_cnt = 0, ov_cnt = 0;
  logic [WIDTH-1:0] last_avg = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    mptr = 0;
  endtask

  task automatic model_push(input logic [WIDTH-1:0] s);
    int sum;
    hist.push_back(int'(s));
    if (hist.size() > DEPTH) void'(hist.pop_front());
    sum = 0;
    foreach (hist[i]) sum += hist[i];
    exp_avg_q.push_back(WIDTH'(sum / DEPTH));
    exp_wr_q.push_back({DEPTH_LOG2'(mptr), s});
    mptr = (mptr + 1) % DEPTH;
  endtask

  // output monitor, sampled 2 time units after the falling edge
  always @(negedge clk) begin
    #2;
    if (bus.mem_we) begin
      we_cnt++;
      we_cyc = cyc;
      if (exp_wr_q.size() == 0) check("unexpected_we", 32'd1, 32'd0);
      else begin
        logic [DEPTH_LOG2+WIDTH-1:0] e;
        e = exp_wr_q.pop_front();
        check("wr_addr", 32'(bus.mem_a), 32'(e[DEPTH_LOG2+WIDTH-1:WIDTH]));
        check("wr_data", 32'(bus.mem_wd), 32'(e[WIDTH-1:0]));
      end
    end
    if (bus.out_valid) begin
      ov_cnt++;
      ov_cyc = cyc;
      last_avg = bus.out_avg;
      if (exp_avg_q.size() == 0) check("unexpected_ov", 32'd1, 32'd0);
      else check("out_avg", 32'(bus.out_avg), 32'(exp_avg_q.pop_front()));
    end
  end

  task automatic send(input logic [WIDTH-1:0] s);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.in_ready) check("ready_timeout", 32'd0, 32'd1);
    else begin
      bus.in_valid  = 1'b1;
      bus.in_sample = s;
      acc_cyc = cyc;
      model_push(s);
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((exp_avg_q.size() != 0 || exp_wr_q.size() != 0 || !bus.in_ready) && n < 60) begin
      @(negedge clk); n++;
    end
    #3;
    if (n >= 60) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input logic pre);
    @(negedge clk);
    reset_n = 1'b0;
    preload = pre;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    preload = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_avg_q.delete();
    exp_wr_q.delete();
    model_clear();
  endtask

  task automatic check_reset_state();
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_avg",   32'(bus.out_avg),   32'd0);
    check("rst_mem_we",    32'(bus.mem_we),    32'd0);
    check("rst_mem_a",     32'(bus.mem_a),     32'd0);
    check("rst_mem_wd",    32'(bus.mem_wd),    32'd0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
  endtask

  initial begin
    int wc, oc, nacc, prev_acc;
    logic [WIDTH-1:0] keep;
    int p;
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;

    // reset state and single sample latency
    do_reset(1'b0);
    #1;
    check_reset_state();
    send(12'd800);
    wait_idle();
    check("lat_we", 32'(we_cyc - acc_cyc), 32'd2);
    check("lat_ov", 32'(ov_cyc - acc_cyc), 32'd3);
    check("avg_800", 32'(last_avg), 32'd100);

    // fill with full-scale samples, then push one zero
    pulse_clear();
    for (int i = 0; i < 8; i++) send(12'd4095);
    wait_idle();
    check("avg_full", 32'(last_avg), 32'd4095);
    check("sum_full", 32'(dut.r_sum), 32'd32760);
    check("ptr_wrap", 32'(bus.mem_a), 32'd0);
    send(12'd0);
    wait_idle();
    check("avg_9th", 32'(last_avg), 32'd3583);
    check("sum_9th", 32'(dut.r_sum), 32'd28665);
    check("ram0_9th", 32'(ram[0]), 32'd0);

    // stale RAM contents must be ignored while the window fills
    do_reset(1'b1);
    check("preload", 32'(ram[5]), 32'd1000);
    for (int i = 0; i < 8; i++) send(12'd8);
    wait_idle();
    check("avg_stale", 32'(last_avg), 32'd8);

    // clear while the controller is in READ
    wc = we_cnt; oc = ov_cnt;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_sample = 12'd500;
    @(negedge clk);
    bus.in_valid = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; model_clear();
    repeat (5) @(negedge clk);
    #3;
    check("clr_no_we", 32'(we_cnt), 32'(wc));
    check("clr_no_ov", 32'(ov_cnt), 32'(oc));
    send(12'd16);
    wait_idle();
    check("avg_16", 32'(last_avg), 32'd2);

    // clear and in_valid together: the sample is dropped
    wc = we_cnt; oc = ov_cnt;
    @(negedge clk);
    clear = 1'b1; bus.in_valid = 1'b1; bus.in_sample = 12'd999;
    @(negedge clk);
    clear = 1'b0; bus.in_valid = 1'b0; model_clear();
    repeat (6) @(negedge clk);
    #3;
    check("drop_no_we", 32'(we_cnt), 32'(wc));
    check("drop_no_ov", 32'(ov_cnt), 32'(oc));
    check("drop_hold",  32'(bus.out_avg), 32'd2);

    // in_valid held high continuously
    nacc = 0; prev_acc = -1;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_sample = 12'd40;
    for (int i = 0; i < 16; i++) begin
      if (bus.in_ready) begin
        if (prev_acc >= 0) check("acc_spacing", 32'(i - prev_acc), 32'd4);
        prev_acc = i;
        nacc++;
        model_push(12'd40);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("acc_count", 32'(nacc), 32'd4);
    wait_idle();

    // reset during UPDATE must not write the RAM
    p = mptr;
    keep = ram[p];
    wc = we_cnt; oc = ov_cnt;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_sample = 12'hABC;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    #1;
    check_reset_state();
    repeat (3) @(negedge clk);
    #3;
    check("rst_ram_keep", 32'(ram[p]), 32'(keep));
    check("rst_no_we", 32'(we_cnt), 32'(wc));
    check("rst_no_ov", 32'(ov_cnt), 32'(oc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
